// File: rtl/datamem_responder_if.sv
// Cache-to-data-memory link: request/write bus from the cache, ready/ack/read bus back.
interface datamem_responder_if;
    logic        MemReq;
    logic        MemRW;
    logic [31:0] MemAddr;
    logic [71:0] MemWrData;
    logic        MemReady;
    logic [72:0] MemRdData;
    logic        MemAck;
    logic        MemErr;

    modport master (
        output MemReq, MemRW, MemAddr, MemWrData,
        input  MemReady, MemRdData, MemAck, MemErr
    );

    modport slave (
        input  MemReq, MemRW, MemAddr, MemWrData,
        output MemReady, MemRdData, MemAck, MemErr
    );
endinterface

// File: rtl/datamem_responder.sv
// Data-memory responder: one line request at a time, fixed LATENCY, 72-bit line array,
// registered ack/err/read-valid pulses in the RESP cycle.
module datamem_responder #(
    parameter int ADDR_LINES = 10,
    parameter int LATENCY    = 4
) (
    input  logic clk,
    input  logic rst,
    datamem_responder_if.slave bus
);
    localparam int         LINES    = 1 << ADDR_LINES;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic accept, done;

    logic        req_rw;
    logic [31:0] req_addr;
    logic [71:0] req_data;
    logic        in_range;
    logic [ADDR_LINES-1:0] idx;

    logic [71:0] mem [LINES];

    logic        ack_q, err_q, vld_q;
    logic [71:0] rd_q;

    assign in_range = (req_addr[31:ADDR_LINES] == '0);
    assign idx      = req_addr[ADDR_LINES-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (bus.MemReq) begin
                accept  = 1'b1;
                state_d = BUSY;
                cnt_d   = CNT_INIT;
            end
            BUSY: if (cnt_q == 4'd0) begin
                done    = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_rw   <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
        end else if (accept) begin
            req_rw   <= bus.MemRW;
            req_addr <= bus.MemAddr;
            req_data <= bus.MemWrData;
        end
    end

    // done is forced low by the async state reset, so a reset before commit drops the write
    always_ff @(posedge clk) begin
        if (done && !req_rw && in_range)
            mem[idx] <= req_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            vld_q <= 1'b0;
            rd_q  <= '0;
        end else begin
            ack_q <= done;
            err_q <= done && !in_range;
            vld_q <= done && req_rw && in_range;
            if (done && req_rw && in_range)
                rd_q <= mem[idx];
        end
    end

    assign bus.MemReady  = (state_q == IDLE);
    assign bus.MemAck    = ack_q;
    assign bus.MemErr    = err_q;
    assign bus.MemRdData = {vld_q, rd_q};
endmodule
